// File: rtl/riscv_timer_pkg.sv
// Shared constants and types for the memory-mapped machine timer.
// Register word indices, ctrl bit layout and reset values live here.
package riscv_timer_pkg;

  localparam int unsigned TMR_IDX_W = 3;

  // Word index of each register (byte address bits [4:2]).
  localparam logic [TMR_IDX_W-1:0] TMR_MTIME_LO    = 3'd0;
  localparam logic [TMR_IDX_W-1:0] TMR_MTIME_HI    = 3'd1;
  localparam logic [TMR_IDX_W-1:0] TMR_MTIMECMP_LO = 3'd2;
  localparam logic [TMR_IDX_W-1:0] TMR_MTIMECMP_HI = 3'd3;
  localparam logic [TMR_IDX_W-1:0] TMR_CTRL        = 3'd4;
  localparam logic [TMR_IDX_W-1:0] TMR_PRESCALE    = 3'd5;

  localparam int unsigned CTRL_CNT_EN_BIT  = 0;
  localparam int unsigned CTRL_INTR_EN_BIT = 1;
  localparam int unsigned CTRL_W           = 2;

  localparam int unsigned MTIME_W = 64;

  typedef struct packed {
    logic intr_en;
    logic cnt_en;
  } ctrl_t;

  localparam logic [MTIME_W-1:0] MTIME_RST    = 64'h0;
  localparam logic [MTIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam ctrl_t              CTRL_RST     = '{intr_en: 1'b0, cnt_en: 1'b0};

  // Word index decoded from a byte address; bits [1:0] are don't-care.
  function automatic logic [TMR_IDX_W-1:0] reg_idx(input logic [4:0] byte_addr);
    return byte_addr[4:2];
  endfunction

endpackage

// File: rtl/riscv_timer_if.sv
// Data-memory bus slice seen by the timer: one-cycle request, ack the next cycle.
interface riscv_timer_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned ADDRW = 12
);
  logic             sel_i;
  logic             we_i;
  logic [ADDRW-1:0] addr_i;
  logic [DW-1:0]    wdata_i;
  logic [DW-1:0]    rdata_o;
  logic             ack_o;

  modport master (
    output sel_i,
    output we_i,
    output addr_i,
    output wdata_i,
    input  rdata_o,
    input  ack_o
  );

  modport slave (
    input  sel_i,
    input  we_i,
    input  addr_i,
    input  wdata_i,
    output rdata_o,
    output ack_o
  );
endinterface

// File: rtl/riscv_timer_prescaler.sv
// Programmable divider: fires tick every prescale+1 enabled cycles.
// tick_o is combinational so a tick lands on the same edge that advances mtime.
module riscv_timer_prescaler #(
  parameter int unsigned PSW = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           clr_i,
  input  logic [PSW-1:0] prescale_i,
  output logic           tick_o
);

  logic [PSW-1:0] pcnt;
  logic           wrap_c;

  assign wrap_c = (pcnt == prescale_i);
  assign tick_o = en_i & wrap_c;

  // A prescale write restarts the period from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      pcnt <= '0;
    end else if (en_i) begin
      if (wrap_c) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PSW'(1);
      end
    end
  end

endmodule

// File: rtl/riscv_timer.sv
// Machine timer: 64-bit mtime/mtimecmp with prescaled counting and a
// registered level interrupt while mtime >= mtimecmp and intr_en is set.
module riscv_timer
  import riscv_timer_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned ADDRW = 12,
  parameter int unsigned PSW   = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  riscv_timer_if.slave   bus,
  output logic           t_intr_o
);

  localparam int unsigned HALF_W = MTIME_W / 2;

  logic [MTIME_W-1:0]   mtime;
  logic [MTIME_W-1:0]   mtimecmp;
  ctrl_t                ctrl;
  logic [PSW-1:0]       prescale;

  logic [MTIME_W-1:0]   mtime_next_c;
  logic [TMR_IDX_W-1:0] idx_c;
  logic                 wr_c;
  logic                 rd_c;
  logic                 wr_mtime_lo_c;
  logic                 wr_mtime_hi_c;
  logic                 wr_cmp_lo_c;
  logic                 wr_cmp_hi_c;
  logic                 wr_ctrl_c;
  logic                 wr_prescale_c;
  logic                 tick_c;
  logic                 cmp_hit_c;
  logic [DW-1:0]        rd_mux_c;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{bus.addr_i[ADDRW-1:5], bus.addr_i[1:0]};

  // Address decode: one transaction per sel cycle, reads and writes never stall.
  assign idx_c         = reg_idx(bus.addr_i[4:0]);
  assign wr_c          = bus.sel_i & bus.we_i;
  assign rd_c          = bus.sel_i & ~bus.we_i;
  assign wr_mtime_lo_c = wr_c & (idx_c == TMR_MTIME_LO);
  assign wr_mtime_hi_c = wr_c & (idx_c == TMR_MTIME_HI);
  assign wr_cmp_lo_c   = wr_c & (idx_c == TMR_MTIMECMP_LO);
  assign wr_cmp_hi_c   = wr_c & (idx_c == TMR_MTIMECMP_HI);
  assign wr_ctrl_c     = wr_c & (idx_c == TMR_CTRL);
  assign wr_prescale_c = wr_c & (idx_c == TMR_PRESCALE);

  riscv_timer_prescaler #(
    .PSW (PSW)
  ) u_prescaler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (ctrl.cnt_en),
    .clr_i      (wr_prescale_c),
    .prescale_i (prescale),
    .tick_o     (tick_c)
  );

  // A software write to either half wins over a same-cycle tick.
  always_comb begin
    mtime_next_c = mtime;
    if (wr_mtime_lo_c) begin
      mtime_next_c[HALF_W-1:0] = bus.wdata_i;
    end else if (wr_mtime_hi_c) begin
      mtime_next_c[MTIME_W-1:HALF_W] = bus.wdata_i;
    end else if (tick_c) begin
      mtime_next_c = mtime + MTIME_W'(1);
    end
  end

  assign cmp_hit_c = (mtime >= mtimecmp);

  // Read mux samples register state before any same-cycle update.
  always_comb begin
    rd_mux_c = '0;
    case (idx_c)
      TMR_MTIME_LO:    rd_mux_c = mtime[HALF_W-1:0];
      TMR_MTIME_HI:    rd_mux_c = mtime[MTIME_W-1:HALF_W];
      TMR_MTIMECMP_LO: rd_mux_c = mtimecmp[HALF_W-1:0];
      TMR_MTIMECMP_HI: rd_mux_c = mtimecmp[MTIME_W-1:HALF_W];
      TMR_CTRL:        rd_mux_c = DW'(ctrl);
      TMR_PRESCALE:    rd_mux_c = DW'(prescale);
      default:         rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime    <= MTIME_RST;
      mtimecmp <= MTIMECMP_RST;
      ctrl     <= CTRL_RST;
      prescale <= '0;
    end else begin
      mtime <= mtime_next_c;
      if (wr_cmp_lo_c) begin
        mtimecmp[HALF_W-1:0] <= bus.wdata_i;
      end
      if (wr_cmp_hi_c) begin
        mtimecmp[MTIME_W-1:HALF_W] <= bus.wdata_i;
      end
      if (wr_ctrl_c) begin
        ctrl.cnt_en  <= bus.wdata_i[CTRL_CNT_EN_BIT];
        ctrl.intr_en <= bus.wdata_i[CTRL_INTR_EN_BIT];
      end
      if (wr_prescale_c) begin
        prescale <= bus.wdata_i[PSW-1:0];
      end
    end
  end

  // Bus response and interrupt are registered; reset drops a pending ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.ack_o   <= 1'b0;
      bus.rdata_o <= '0;
      t_intr_o    <= 1'b0;
    end else begin
      bus.ack_o   <= bus.sel_i;
      bus.rdata_o <= rd_c ? rd_mux_c : '0;
      t_intr_o    <= ctrl.intr_en & cmp_hit_c;
    end
  end

endmodule

// File: tb/tb_riscv_timer.sv
// Self-checking bench for riscv_timer: directed scenarios plus random bus
// traffic, every cycle compared against a behavioural timer model.
module tb_riscv_timer;

  logic clk;
  logic rst;
  logic t_intr;

  riscv_timer_if #(.DW(32), .ADDRW(12)) bus ();

  riscv_timer #(
    .DW    (32),
    .ADDRW (12),
    .PSW   (16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .t_intr_o (t_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Behavioural model: plain 64-bit integers and an enabled-cycle counter.
  longint unsigned m_mtime;
  longint unsigned m_cmp;
  bit              m_cnt_en;
  bit              m_intr_en;
  int unsigned     m_prescale;
  int unsigned     m_since;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_mtime    = 64'd0;
    m_cmp      = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt_en   = 1'b0;
    m_intr_en  = 1'b0;
    m_prescale = 0;
    m_since    = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a[4:2])
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_mtime[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {30'd0, m_intr_en, m_cnt_en};
      3'd5:    return m_prescale;
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, predict from pre-edge model state, clock, compare.
  task automatic cycle(input bit s, input bit w, input logic [11:0] a, input logic [31:0] d);
    bit              e_ack;
    bit              e_int;
    bit              tick;
    logic [31:0]     e_rd;
    longint unsigned old;
    bus.sel_i   = s;
    bus.we_i    = w;
    bus.addr_i  = a;
    bus.wdata_i = d;
    e_ack = s && !rst;
    e_rd  = (s && !w && !rst) ? model_read(a) : 32'd0;
    e_int = !rst && m_intr_en && (m_mtime >= m_cmp);
    tick  = m_cnt_en && (m_since == m_prescale);
    if (rst) begin
      model_reset();
    end else begin
      old = m_mtime;
      if (m_cnt_en) m_since = tick ? 0 : m_since + 1;
      if (tick) m_mtime = m_mtime + 1;
      if (s && w) begin
        case (a[4:2])
          3'd0: m_mtime = {old[63:32], d};
          3'd1: m_mtime = {d, old[31:0]};
          3'd2: m_cmp   = {m_cmp[63:32], d};
          3'd3: m_cmp   = {d, m_cmp[31:0]};
          3'd4: begin m_cnt_en = d[0]; m_intr_en = d[1]; end
          3'd5: begin m_prescale = d[15:0]; m_since = 0; end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("ack", 64'(bus.ack_o), 64'(e_ack));
    check("rdata", 64'(bus.rdata_o), 64'(e_rd));
    check("t_intr", 64'(t_intr), 64'(e_int));
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    cycle(1'b1, 1'b0, a, 32'd0);
    check(tag, 64'(bus.rdata_o), 64'(exp));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 12'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_data(input logic [11:0] a);
    int unsigned k;
    k = $urandom_range(0, 9);
    if (a[4:2] == 3'd5) return (k < 8) ? 32'($urandom_range(0, 3)) : $urandom;
    if (k < 4) return 32'($urandom_range(0, 40));
    if (k < 6) return 32'hFFFF_FFFF;
    return $urandom;
  endfunction

  int hit_cyc;
  int rise_cyc;

  initial begin
    rst = 1'b1;
    bus.sel_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
    model_reset();
    idle();
    idle();
    rst = 1'b0;

    // Reset values of every register.
    rd("rst_mtime_lo", 12'h000, 32'h0);
    rd("rst_mtime_hi", 12'h004, 32'h0);
    rd("rst_cmp_lo",   12'h008, 32'hFFFF_FFFF);
    rd("rst_cmp_hi",   12'h00C, 32'hFFFF_FFFF);
    rd("rst_ctrl",     12'h010, 32'h0);
    rd("rst_prescale", 12'h014, 32'h0);

    // Prescale 3, compare at 10, interrupt one cycle after mtime reaches it.
    wr(12'h014, 32'd3);
    wr(12'h00C, 32'd0);
    wr(12'h008, 32'd10);
    wr(12'h010, 32'd3);
    hit_cyc  = -1;
    rise_cyc = -100;
    for (int i = 0; i < 80; i++) begin
      cycle(1'b1, 1'b0, 12'h000, 32'd0);
      if (hit_cyc < 0 && m_mtime >= 10) hit_cyc = cyc;
      if (t_intr === 1'b1) begin
        rise_cyc = cyc;
        break;
      end
    end
    check("intr_latency", 64'(rise_cyc - hit_cyc), 64'd1);

    // Larger compare clears the interrupt two cycles after the write.
    wr(12'h008, 32'd100);
    check("intr_hold", 64'(t_intr), 64'd1);
    idle();
    check("intr_fall", 64'(t_intr), 64'd0);

    // Carry from lo into hi, then full 64-bit wrap, one tick each.
    wr(12'h010, 32'd0);
    wr(12'h014, 32'd0);
    wr(12'h004, 32'd0);
    wr(12'h000, 32'hFFFF_FFFF);
    wr(12'h010, 32'd1);
    wr(12'h010, 32'd0);
    rd("carry_lo", 12'h000, 32'd0);
    rd("carry_hi", 12'h004, 32'd1);
    wr(12'h004, 32'hFFFF_FFFF);
    wr(12'h000, 32'hFFFF_FFFF);
    wr(12'h010, 32'd1);
    wr(12'h010, 32'd0);
    rd("wrap_lo", 12'h000, 32'd0);
    rd("wrap_hi", 12'h004, 32'd0);

    // Write beats a same-cycle tick.
    wr(12'h010, 32'd1);
    idle();
    wr(12'h000, 32'h50);
    rd("wr_wins", 12'h000, 32'h50);
    wr(12'h010, 32'd0);

    // Back-to-back reads, then reset with a transaction in flight.
    wr(12'h010, 32'd3);
    cycle(1'b1, 1'b0, 12'h000, 32'd0);
    cycle(1'b1, 1'b0, 12'h01C, 32'd0);
    check("b2b_unmapped", 64'(bus.rdata_o), 64'd0);
    cycle(1'b1, 1'b0, 12'h010, 32'd0);
    check("b2b_ctrl", 64'(bus.rdata_o), 64'd3);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 12'h000, 32'd0);
    check("rst_drop_ack", 64'(bus.ack_o), 64'd0);
    rst = 1'b0;
    rd("rst2_cmp_lo", 12'h008, 32'hFFFF_FFFF);
    rd("rst2_cmp_hi", 12'h00C, 32'hFFFF_FFFF);
    rd("rst2_ctrl",   12'h010, 32'h0);
    rd("rst2_mtime",  12'h000, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] a;
      a   = 12'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 1) begin
        cycle(1'b1, ($urandom_range(0, 2) == 0), a, rand_data(a));
      end else begin
        idle();
      end
    end
    rst = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
